ordersorter_burst: RTL and testbench

Parametrised command parser between the FTDI receive FIFO and the register file: consumes header/address/length/payload bytes from `ri_data` and issues single-cycle `write`/`read` strobes to the register file. It is the successor to the fixed-format order sorter, adding:
- configurable address and length field widths;
- per-command address auto-increment with wrap-around;
- read-burst backpressure;
- an optional stall timeout.

---
 rtl/ordersorter_burst.sv | 181 ++++++++++++++++++
 tb/tb_ordersorter_burst.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ordersorter_burst.sv
// Byte-stream command parser: header/address/length/payload from the receive FIFO into register strobes.
// Optional stall timeout is compiled in with `define ORDERSORTER_TIMEOUT_EN.
module ordersorter_burst #(
    parameter int ADDR_BYTES     = 1,
    parameter int LEN_BYTES      = 2,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                    clk,
    input  logic                    res_n,
    input  logic [7:0]              ri_data,
    input  logic                    ri_empty,
    output logic                    ri_read,
    input  logic                    pcreadfifofull,
    output logic [7:0]              header,
    output logic [8*ADDR_BYTES-1:0] address,
    output logic [8*LEN_BYTES-1:0]  length,
    output logic [7:0]              value,
    output logic                    write,
    output logic                    read,
    output logic [3:0]              state,
    output logic                    busy,
    output logic                    timeout_err
);
    localparam int AW = 8 * ADDR_BYTES;
    localparam int LW = 8 * LEN_BYTES;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ADDR  = 4'd1,
        S_LEN   = 4'd2,
        S_WDATA = 4'd3,
        S_READ  = 4'd4
    } state_t;

    localparam logic [1:0]    A_LAST   = 2'(ADDR_BYTES - 1);
    localparam logic [1:0]    L_LAST   = 2'(LEN_BYTES - 1);
    localparam logic [LW-1:0] LEN_ZERO = {LW{1'b0}};
    localparam logic [LW-1:0] LEN_ONE  = {{(LW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t          r_state;
    state_t          w_next;
    logic            r_pending;
    logic [1:0]      r_idx;
    logic            w_hdr_ok;
    logic            w_is_write;
    logic            w_autoinc;
    logic            w_read;
    logic            w_fetch;
    logic            w_tmo;
    logic [AW+7:0]   w_addr_wide;
    logic [LW+7:0]   w_len_wide;

    assign w_hdr_ok    = (ri_data[7:6] == 2'b01) || (ri_data[7:6] == 2'b10);
    assign w_is_write  = (header[7:6] == 2'b01);
    assign w_autoinc   = header[0];
    assign w_addr_wide = {address, ri_data};
    assign w_len_wide  = {length, ri_data};
    // read is combinational so backpressure blocks the strobe in the very cycle it is raised
    assign w_read      = (r_state == S_READ) && !pcreadfifofull && (length != LEN_ZERO);
    // a new fetch may start on the capture edge, but never toward READ, which consumes no bytes
    assign w_fetch     = !ri_empty && !ri_read && (w_next != S_READ) && !w_tmo;

    assign read  = w_read;
    assign state = r_state;
    assign busy  = (r_state != S_IDLE);

`ifdef ORDERSORTER_TIMEOUT_EN
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT_CYCLES - 1);
    logic [31:0] r_tmo_cnt;
    logic        w_stall_state;

    assign w_stall_state = (r_state == S_ADDR) || (r_state == S_LEN) || (r_state == S_WDATA);
    assign w_tmo         = w_stall_state && !r_pending && (r_tmo_cnt >= TMO_LAST);

    // stall counter: runs while waiting for bytes, restarts on every captured byte
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_tmo_cnt <= 32'd0;
        end else if (w_stall_state && !r_pending && !w_tmo) begin
            r_tmo_cnt <= r_tmo_cnt + 32'd1;
        end else begin
            r_tmo_cnt <= 32'd0;
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = (TIMEOUT_CYCLES == 32'sd0);
    assign w_tmo        = 1'b0;
`endif

    // next-state decode
    always_comb begin
        w_next = r_state;
        if (w_tmo) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (r_pending && w_hdr_ok) w_next = S_ADDR; else w_next = S_IDLE;
                S_ADDR:  if (r_pending && (r_idx == A_LAST)) w_next = S_LEN; else w_next = S_ADDR;
                S_LEN: begin
                    if (r_pending && (r_idx == L_LAST)) begin
                        if (w_len_wide[LW-1:0] == LEN_ZERO) w_next = S_IDLE;
                        else if (w_is_write)                w_next = S_WDATA;
                        else                                w_next = S_READ;
                    end else begin
                        w_next = S_LEN;
                    end
                end
                S_WDATA: if (write && (length == LEN_ONE)) w_next = S_IDLE; else w_next = S_WDATA;
                S_READ:  if ((length == LEN_ZERO) || (w_read && (length == LEN_ONE))) w_next = S_IDLE;
                         else w_next = S_READ;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // command FSM, byte fetch and registered outputs
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            r_state     <= S_IDLE;
            r_pending   <= 1'b0;
            r_idx       <= 2'd0;
            ri_read     <= 1'b0;
            header      <= 8'h00;
            address     <= {AW{1'b0}};
            length      <= LEN_ZERO;
            value       <= 8'h00;
            write       <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            r_state     <= w_next;
            ri_read     <= w_fetch;
            r_pending   <= ri_read && !w_tmo;
            write       <= 1'b0;
            timeout_err <= w_tmo;
            if (w_tmo) begin
                length <= LEN_ZERO;
                r_idx  <= 2'd0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (r_pending && w_hdr_ok) begin
                            header <= ri_data;
                            r_idx  <= 2'd0;
                        end
                    end
                    S_ADDR: begin
                        if (r_pending) begin
                            address <= w_addr_wide[AW-1:0];
                            r_idx   <= (r_idx == A_LAST) ? 2'd0 : r_idx + 2'd1;
                        end
                    end
                    S_LEN: begin
                        if (r_pending) begin
                            length <= w_len_wide[LW-1:0];
                            r_idx  <= (r_idx == L_LAST) ? 2'd0 : r_idx + 2'd1;
                        end
                    end
                    S_WDATA: begin
                        // address/length move on the cycle after the strobe they belong to
                        if (r_pending) begin
                            value <= ri_data;
                            write <= 1'b1;
                        end else if (write && (length != LEN_ZERO)) begin
                            length <= length - LEN_ONE;
                            if (w_autoinc) address <= address + ADDR_ONE;
                        end
                    end
                    S_READ: begin
                        if (w_read) begin
                            length <= length - LEN_ONE;
                            if (w_autoinc) address <= address + ADDR_ONE;
                        end
                    end
                    default: r_idx <= 2'd0;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ordersorter_burst.sv
// Scoreboard bench for ordersorter_burst: a byte-stream reference model predicts every strobe,
// a negedge monitor pops and compares; FIFO behaviour is modelled in the bench.
module tb_ordersorter_burst;
    localparam int AB  = 1;
    localparam int LB  = 2;
    localparam int TMO = 50;

    logic              clk            = 1'b0;
    logic              res_n          = 1'b1;
    logic [7:0]        ri_data        = 8'h00;
    logic              ri_empty       = 1'b1;
    logic              pcreadfifofull = 1'b0;
    logic              ri_read;
    logic [7:0]        header;
    logic [8*AB-1:0]   address;
    logic [8*LB-1:0]   length;
    logic [7:0]        value;
    logic              write;
    logic              read;
    logic [3:0]        state;
    logic              busy;
    logic              timeout_err;

    typedef struct {
        bit wr;
        int addr;
        int val;
        int len;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] fifo[$];
    int n_checks  = 0;
    int n_fail    = 0;
    int n_strobes = 0;
    int n_tmo     = 0;

    always #5 clk = ~clk;

    ordersorter_burst #(.ADDR_BYTES(AB), .LEN_BYTES(LB), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .res_n(res_n), .ri_data(ri_data), .ri_empty(ri_empty), .ri_read(ri_read),
        .pcreadfifofull(pcreadfifofull), .header(header), .address(address), .length(length),
        .value(value), .write(write), .read(read), .state(state), .busy(busy),
        .timeout_err(timeout_err)
    );

    // receive FIFO: data appears the cycle after ri_read
    always @(posedge clk) begin
        if (ri_read && !ri_empty) ri_data <= fifo.pop_front();
        ri_empty <= (fifo.size() == 0);
    end

    task automatic check(input string name, input logic ok, input string detail);
        n_checks++;
        if (ok !== 1'b1) begin
            n_fail++;
            $display("FAIL %s: %s", name, detail);
        end
    endtask

    // reference: walk the byte stream command by command and list the strobes it must produce
    task automatic model(input logic [7:0] b[$]);
        int i, a, len;
        logic [7:0] h;
        exp_t e;
        i = 0;
        while (i < b.size()) begin
            h = b[i];
            i++;
            if (h[7:6] == 2'b01 || h[7:6] == 2'b10) begin
                a = 0;
                len = 0;
                for (int k = 0; k < AB; k++) begin a = a * 256 + int'(b[i]); i++; end
                for (int k = 0; k < LB; k++) begin len = len * 256 + int'(b[i]); i++; end
                for (int n = 0; n < len; n++) begin
                    if (h[7:6] == 2'b01 && i >= b.size()) break;
                    e.wr   = (h[7:6] == 2'b01);
                    e.addr = a;
                    e.len  = len - n;
                    e.val  = e.wr ? int'(b[i]) : 0;
                    if (e.wr) i++;
                    exp_q.push_back(e);
                    if (h[0]) a = (a + 1) % (1 << (8 * AB));
                end
            end
        end
    endtask

    task automatic feed(input logic [7:0] b[$]);
        model(b);
        foreach (b[k]) fifo.push_back(b[k]);
    endtask

    task automatic send(input int n, input logic [127:0] v);
        logic [7:0] b[$];
        for (int k = 0; k < n; k++) b.push_back(v[8*(n-1-k) +: 8]);
        feed(b);
    endtask

    task automatic settle(input string name, input bit rand_full);
        int c = 0;
        while (c < 3000 && !(fifo.size() == 0 && exp_q.size() == 0 && state == 4'd0 && !ri_read)) begin
            @(posedge clk); #1;
            if (rand_full) pcreadfifofull = ($urandom_range(0, 3) == 0);
            c++;
        end
        pcreadfifofull = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check({name, "_done"}, exp_q.size() == 0 && state == 4'd0 && c < 3000,
              $sformatf("got pending=%0d state=%0d cycles=%0d, expected pending=0 state=0", exp_q.size(), state, c));
    endtask

    task automatic wait_strobes(input string name, input int target);
        int c = 0;
        while (n_strobes < target && c < 300) begin @(posedge clk); #1; c++; end
        check(name, n_strobes >= target, $sformatf("got %0d strobes, expected %0d", n_strobes, target));
    endtask

    function automatic logic outs_zero();
        return {ri_read, header, address, length, value, write, read, state, busy, timeout_err} == '0;
    endfunction

    // monitor: compare every strobe against the scoreboard plus protocol rules
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (res_n) begin
                check("busy", busy == (state != 4'd0), $sformatf("got busy=%0d, state=%0d", busy, state));
                check("fifo_underrun", !(ri_read && ri_empty), "got ri_read while empty, expected none");
                check("dual_strobe", !(write && read), "got write and read together, expected exclusive");
                if (state == 4'd4) check("ri_read_in_read", !ri_read, "got ri_read=1 in READ, expected 0");
                if (timeout_err) n_tmo++;
                if (write || read) begin
                    n_strobes++;
                    if (read) check("read_while_full", !pcreadfifofull, "got read with pcreadfifofull=1, expected none");
                    check("strobe_expected", exp_q.size() != 0,
                          $sformatf("got %s at addr %0h, expected no strobe", write ? "write" : "read", address));
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("strobe", write == e.wr && int'(address) == e.addr && int'(length) == e.len &&
                              (!e.wr || int'(value) == e.val),
                              $sformatf("got wr=%0d addr=%0h len=%0d val=%0h, expected wr=%0d addr=%0h len=%0d val=%0h",
                                        write, address, length, value, e.wr, e.addr, e.len, e.val));
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] b[$];
        int base, t0, kind, len;
        #2 res_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_state", outs_zero(), $sformatf("got state=%0d ri_read=%0d addr=%0h len=%0d, expected all 0",
              state, ri_read, address, length));
        res_n = 1'b1;

        send(7, 56'h41_10_00_03_AA_BB_CC);
        settle("wr_autoinc", 1'b0);
        send(7, 56'h40_10_00_03_AA_BB_CC);
        settle("wr_fixed", 1'b0);

        base = n_strobes;
        send(4, 32'h81_20_00_04);
        wait_strobes("bp_two_pulses", base + 2);
        pcreadfifofull = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        pcreadfifofull = 1'b0;
        settle("read_bp", 1'b0);

        send(10, 80'h40_05_00_00_C3_41_07_00_01_5A);
        settle("len0_invalid", 1'b0);
        send(6, 48'h41_FF_00_02_11_22);
        settle("addr_wrap", 1'b0);

        for (int r = 0; r < 30; r++) begin
            b.delete();
            for (int c = 0; c < 4; c++) begin
                kind = $urandom_range(0, 4);
                if (kind == 4) begin
                    b.push_back({($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00, 6'($urandom)});
                end else begin
                    b.push_back({(kind < 2) ? 2'b01 : 2'b10, 5'($urandom), 1'($urandom)});
                    b.push_back(8'($urandom));
                    len = $urandom_range(0, 5);
                    b.push_back(8'h00);
                    b.push_back(8'(len));
                    if (kind < 2) for (int k = 0; k < len; k++) b.push_back(8'($urandom));
                end
            end
            feed(b);
            settle("random", 1'b1);
        end

        base = n_strobes;
        send(6, 48'h41_30_00_04_01_02);
        wait_strobes("partial_writes", base + 2);
        @(posedge clk);
        #2 res_n = 1'b0;
        #1;
        check("reset_mid_cmd", outs_zero(), $sformatf("got state=%0d ri_read=%0d write=%0d addr=%0h, expected all 0",
              state, ri_read, write, address));
        @(posedge clk);
        #1 res_n = 1'b1;
        send(5, 40'h41_07_00_01_5A);
        settle("after_reset", 1'b0);

        t0 = n_tmo;
        send(1, 8'h41);
        repeat (TMO + 20) @(posedge clk);
        #1;
`ifdef ORDERSORTER_TIMEOUT_EN
        check("timeout_pulse", (n_tmo - t0) == 1, $sformatf("got %0d pulse cycles, expected 1", n_tmo - t0));
        check("timeout_state", state == 4'd0 && length == '0, $sformatf("got state=%0d len=%0d, expected 0/0", state, length));
`else
        check("stall_hold", state == 4'd1 && (n_tmo - t0) == 0,
              $sformatf("got state=%0d timeout pulses=%0d, expected state=1 pulses=0", state, n_tmo - t0));
        res_n = 1'b0;
        @(posedge clk);
        #1 res_n = 1'b1;
`endif
        send(5, 40'h41_07_00_01_5A);
        settle("after_stall", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
